arith_op_controller: RTL and testbench

- Sequencer for the shared arithmetic datapath: divider (op 00), multiplier (op 01), square root (op 10).
- Accepts one operation request at a time and registers the operands.
- Issues a one-cycle start pulse to the selected unit and waits for that unit's done.
- Drives the 3-to-1 result mux selector, captures the selected result and returns it with a one-cycle Done pulse.

---
 rtl/arith_op_controller.sv | 138 +++++++++++++
 tb/tb_arith_op_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/arith_op_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : arith_op_controller                                              |
// | Purpose  : Sequences one div/mult/sqrt request at a time through the shared |
// |            arithmetic datapath and returns the muxed result with a pulse.   |
// | Options  : ARITH_CTRL_TIMEOUT_EN enables the WAIT-state abort counter.      |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module arith_op_controller #(
  parameter int NBITS          = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Op_Code,
  input  logic [NBITS-1:0] Operand_A,
  input  logic [NBITS-1:0] Operand_B,
  input  logic             Div_Done,
  input  logic             Mult_Done,
  input  logic             Sqrt_Done,
  input  logic [NBITS-1:0] Mux_Result,
  output logic             Div_Start,
  output logic             Mult_Start,
  output logic             Sqrt_Start,
  output logic [NBITS-1:0] Unit_A,
  output logic [NBITS-1:0] Unit_B,
  output logic [1:0]       Mux_Selector,
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic [NBITS-1:0] Result
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    ERR    = 2'd3
  } state_t;

  localparam logic [1:0] OP_DIV     = 2'b00;
  localparam logic [1:0] OP_MULT    = 2'b01;
  localparam logic [1:0] OP_SQRT    = 2'b10;
  localparam logic [1:0] OP_INVALID = 2'b11;

  state_t state;
  state_t state_next;
  logic   sel_done;
  logic   timeout_hit;
  logic   accept;

  // Mux_Selector doubles as the latched op: it is only loaded on a valid accept.
  always_comb begin
    sel_done = 1'b0;
    case (Mux_Selector)
      OP_DIV:  sel_done = Div_Done;
      OP_MULT: sel_done = Mult_Done;
      OP_SQRT: sel_done = Sqrt_Done;
      default: sel_done = 1'b0;
    endcase
  end

`ifdef ARITH_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == LAUNCH) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Last allowed WAIT cycle is the one in which the count would reach the limit.
  assign timeout_hit = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_hit        = 1'b0;
`endif

  assign accept = (state == IDLE) && Start && (Op_Code != OP_INVALID);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (Start) begin
          state_next = (Op_Code == OP_INVALID) ? ERR : LAUNCH;
        end
      end
      LAUNCH:  state_next = WAIT;
      WAIT: begin
        if (sel_done) begin
          state_next = IDLE;
        end else if (timeout_hit) begin
          state_next = ERR;
        end
      end
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign Div_Start  = (state == LAUNCH) && (Mux_Selector == OP_DIV);
  assign Mult_Start = (state == LAUNCH) && (Mux_Selector == OP_MULT);
  assign Sqrt_Start = (state == LAUNCH) && (Mux_Selector == OP_SQRT);
  assign Busy       = (state != IDLE);
  assign Error      = (state == ERR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      Unit_A       <= '0;
      Unit_B       <= '0;
      Mux_Selector <= OP_INVALID;
      Result       <= '0;
      Done         <= 1'b0;
    end else begin
      state <= state_next;
      Done  <= (state == WAIT) && sel_done;
      if (accept) begin
        Unit_A       <= Operand_A;
        Unit_B       <= Operand_B;
        Mux_Selector <= Op_Code;
      end
      if ((state == WAIT) && sel_done) begin
        Result <= Mux_Result;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arith_op_controller.sv
`default_nettype none
// Scoreboard bench for arith_op_controller: directed requests push expected
// Done/Error responses; a negedge monitor pops and compares them.
module tb_arith_op_controller;

  localparam int NB = 16;

  logic          clk;
  logic          reset;
  logic          Start;
  logic [1:0]    Op_Code;
  logic [NB-1:0] Operand_A;
  logic [NB-1:0] Operand_B;
  logic          Div_Done;
  logic          Mult_Done;
  logic          Sqrt_Done;
  logic [NB-1:0] Mux_Result;
  logic          Div_Start;
  logic          Mult_Start;
  logic          Sqrt_Start;
  logic [NB-1:0] Unit_A;
  logic [NB-1:0] Unit_B;
  logic [1:0]    Mux_Selector;
  logic          Busy;
  logic          Done;
  logic          Error;
  logic [NB-1:0] Result;

  arith_op_controller #(.NBITS(NB), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Op_Code(Op_Code),
    .Operand_A(Operand_A), .Operand_B(Operand_B),
    .Div_Done(Div_Done), .Mult_Done(Mult_Done), .Sqrt_Done(Sqrt_Done),
    .Mux_Result(Mux_Result),
    .Div_Start(Div_Start), .Mult_Start(Mult_Start), .Sqrt_Start(Sqrt_Start),
    .Unit_A(Unit_A), .Unit_B(Unit_B), .Mux_Selector(Mux_Selector),
    .Busy(Busy), .Done(Done), .Error(Error), .Result(Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            is_err;
    logic [NB-1:0] res;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;
  int   div_cnt = 0;
  int   mult_cnt = 0;
  int   sqrt_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end else begin
      passed++;
    end
  endtask

  task automatic push_exp(input bit is_err, input logic [NB-1:0] res);
    exp_t e;
    e.is_err = is_err;
    e.res    = res;
    exp_q.push_back(e);
  endtask

  // Drive a request for one cycle; returns at the negedge of the following cycle.
  task automatic issue(input logic [1:0] op, input logic [NB-1:0] a, input logic [NB-1:0] b);
    Start     = 1'b1;
    Op_Code   = op;
    Operand_A = a;
    Operand_B = b;
    @(negedge clk);
    Start = 1'b0;
  endtask

  // After n cycles raise the chosen unit's done for one cycle with the given result.
  task automatic unit_done(input int sel, input logic [NB-1:0] res, input int n);
    repeat (n) @(negedge clk);
    Mux_Result = res;
    case (sel)
      0:       Div_Done  = 1'b1;
      1:       Mult_Done = 1'b1;
      default: Sqrt_Done = 1'b1;
    endcase
    @(negedge clk);
    Div_Done   = 1'b0;
    Mult_Done  = 1'b0;
    Sqrt_Done  = 1'b0;
    Mux_Result = '0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && (Done || Error)) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_response: Done=%0b Error=%0b Result=%0d, none expected (t=%0t)",
                 Done, Error, Result, $time);
      end else begin
        e = exp_q.pop_front();
        check("resp_error", {31'd0, Error}, {31'd0, e.is_err});
        check("resp_done", {31'd0, Done}, {31'd0, !e.is_err});
        check("resp_result", {16'd0, Result}, {16'd0, e.res});
      end
    end
    div_cnt  += int'(Div_Start);
    mult_cnt += int'(Mult_Start);
    sqrt_cnt += int'(Sqrt_Start);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, m0;
    reset = 1'b1; Start = 1'b0; Op_Code = '0; Operand_A = '0; Operand_B = '0;
    Div_Done = 1'b0; Mult_Done = 1'b0; Sqrt_Done = 1'b0; Mux_Result = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, Busy}, 0);
    check("rst_done", {31'd0, Done}, 0);
    check("rst_error", {31'd0, Error}, 0);
    check("rst_result", {16'd0, Result}, 0);
    check("rst_unit_a", {16'd0, Unit_A}, 0);
    check("rst_unit_b", {16'd0, Unit_B}, 0);
    check("rst_sel", {30'd0, Mux_Selector}, 3);
    check("rst_starts", {29'd0, Div_Start, Mult_Start, Sqrt_Start}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Divide 100/7 -> 14
    push_exp(1'b0, 16'd14);
    issue(2'b00, 16'd100, 16'd7);
    check("div_launch_start", {29'd0, Div_Start, Mult_Start, Sqrt_Start}, 3'b100);
    check("div_launch_busy", {31'd0, Busy}, 1);
    check("div_sel", {30'd0, Mux_Selector}, 0);
    check("div_unit_a", {16'd0, Unit_A}, 100);
    check("div_unit_b", {16'd0, Unit_B}, 7);
    unit_done(0, 16'd14, 5);
    check("div_busy_after", {31'd0, Busy}, 0);
    @(negedge clk);
    check("div_done_one_cycle", {31'd0, Done}, 0);
    check("div_start_count", div_cnt, 1);

    // Multiply 12*11 -> 132, then sqrt(81) accepted in the Done cycle
    push_exp(1'b0, 16'd132);
    issue(2'b01, 16'd12, 16'd11);
    check("mult_launch_start", {29'd0, Div_Start, Mult_Start, Sqrt_Start}, 3'b010);
    check("mult_sel", {30'd0, Mux_Selector}, 1);
    unit_done(1, 16'd132, 3);
    push_exp(1'b0, 16'd9);
    issue(2'b10, 16'd81, 16'd0);
    check("sqrt_launch_start", {29'd0, Div_Start, Mult_Start, Sqrt_Start}, 3'b001);
    check("sqrt_sel", {30'd0, Mux_Selector}, 2);
    check("sqrt_unit_a", {16'd0, Unit_A}, 81);
    unit_done(2, 16'd9, 2);
    @(negedge clk);
    check("sqrt_sel_kept", {30'd0, Mux_Selector}, 2);
    check("sqrt_result_held", {16'd0, Result}, 9);

    // Invalid op -> one-cycle Error, Result unchanged, no start
    d0 = div_cnt; m0 = mult_cnt;
    push_exp(1'b1, 16'd9);
    issue(2'b11, 16'd55, 16'd55);
    check("err_busy", {31'd0, Busy}, 1);
    check("err_no_start", {29'd0, Div_Start, Mult_Start, Sqrt_Start}, 0);
    check("err_unit_a_kept", {16'd0, Unit_A}, 81);
    @(negedge clk);
    check("err_one_cycle", {31'd0, Error}, 0);
    check("err_idle", {31'd0, Busy}, 0);

    // Interference: dones during LAUNCH/WAIT from wrong units and a Start while busy
    push_exp(1'b0, 16'd30);
    issue(2'b01, 16'd5, 16'd6);
    Mult_Done = 1'b1; Mux_Result = 16'd77;
    @(negedge clk);
    Mult_Done = 1'b0;
    Div_Done = 1'b1; Sqrt_Done = 1'b1; Mux_Result = 16'd999;
    Start = 1'b1; Op_Code = 2'b00; Operand_A = 16'd1;
    @(negedge clk);
    Div_Done = 1'b0; Sqrt_Done = 1'b0; Mux_Result = '0; Start = 1'b0;
    check("intf_still_busy", {31'd0, Busy}, 1);
    unit_done(1, 16'd30, 2);
    @(negedge clk);
    check("intf_mult_starts", mult_cnt - m0, 1);
    check("intf_div_starts", div_cnt - d0, 0);
    check("intf_unit_a", {16'd0, Unit_A}, 5);

    // Reset in WAIT
    issue(2'b00, 16'd50, 16'd5);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'd0, Busy}, 0);
    check("midrst_result", {16'd0, Result}, 0);
    check("midrst_sel", {30'd0, Mux_Selector}, 3);
    check("midrst_unit_a", {16'd0, Unit_A}, 0);
    reset = 1'b0;
    Div_Done = 1'b1; Mux_Result = 16'd10;
    @(negedge clk);
    Div_Done = 1'b0; Mux_Result = '0;
    @(negedge clk);
    check("midrst_no_done", {31'd0, Done}, 0);

    // Recovery: sqrt(144) -> 12
    push_exp(1'b0, 16'd12);
    issue(2'b10, 16'd144, 16'd0);
    unit_done(2, 16'd12, 1);
    @(negedge clk);

`ifdef ARITH_CTRL_TIMEOUT_EN
    // Sqrt that never completes aborts after 8 WAIT cycles
    push_exp(1'b1, 16'd12);
    issue(2'b10, 16'd200, 16'd0);
    repeat (10) @(negedge clk);
    check("tmo_idle", {31'd0, Busy}, 0);
    push_exp(1'b0, 16'd15);
    issue(2'b01, 16'd3, 16'd5);
    unit_done(1, 16'd15, 1);
    @(negedge clk);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
